// File: rtl/clint_smp.sv
// Core-local interruptor for an SMP cluster: shared 64-bit mtime with a prescaler,
// plus per-hart mtimecmp and msip registers behind a 32-bit register port.
module clint_smp #(
  parameter int N_HARTS  = 1,
  parameter int TICK_DIV = 1
) (
  input  logic               CLK,
  input  logic               RST_X,
  input  logic               w_we,
  input  logic               w_re,
  input  logic [15:0]        w_addr,
  input  logic [31:0]        w_wdata,
  output logic [31:0]        w_rdata,
  output logic               w_rvalid,
  output logic [N_HARTS-1:0] w_mtip,
  output logic [N_HARTS-1:0] w_msip,
  output logic [63:0]        w_mtime
);

  logic [15:0]        r_presc;
  logic [63:0]        r_mtime;
  logic [63:0]        r_mtimecmp [N_HARTS];
  logic [N_HARTS-1:0] r_msip;
  logic [N_HARTS-1:0] r_mtip;
  logic [31:0]        r_rdata;
  logic               r_rvalid;

  logic        w_tick;
  logic        w_msipRgn;
  logic        w_cmpRgn;
  logic        w_mtimeLo;
  logic        w_mtimeHi;
  logic [3:0]  w_msipIdx;
  logic [3:0]  w_cmpIdx;
  logic        w_cmpHiHalf;
  logic [31:0] w_rdSel;
  logic        w_unusedLowAddr;

  assign w_tick          = (r_presc == 16'(TICK_DIV - 1));
  assign w_msipRgn       = (w_addr[15:6] == 10'd0);
  assign w_cmpRgn        = (w_addr[15:7] == 9'b0100_0000_0);
  assign w_mtimeLo       = (w_addr[15:2] == 14'h2FFE);
  assign w_mtimeHi       = (w_addr[15:2] == 14'h2FFF);
  assign w_msipIdx       = w_addr[5:2];
  assign w_cmpIdx        = w_addr[6:3];
  assign w_cmpHiHalf     = w_addr[2];
  assign w_unusedLowAddr = ^w_addr[1:0];

  // Hart slots beyond N_HARTS never match, so they read back as zero.
  always_comb begin
    w_rdSel = 32'd0;
    for (int h = 0; h < N_HARTS; h++) begin
      if (w_msipRgn && (w_msipIdx == 4'(h)))
        w_rdSel = {31'd0, r_msip[h]};
      if (w_cmpRgn && (w_cmpIdx == 4'(h)))
        w_rdSel = w_cmpHiHalf ? r_mtimecmp[h][63:32] : r_mtimecmp[h][31:0];
    end
    if (w_mtimeLo)
      w_rdSel = r_mtime[31:0];
    if (w_mtimeHi)
      w_rdSel = r_mtime[63:32];
  end

  // A software write to mtime wins over a coincident tick; the prescaler keeps running.
  always_ff @(posedge CLK) begin
    if (!RST_X) begin
      r_presc <= 16'd0;
      r_mtime <= 64'd0;
    end else begin
      r_presc <= w_tick ? 16'd0 : r_presc + 16'd1;
      if (w_we && w_mtimeLo)
        r_mtime[31:0] <= w_wdata;
      else if (w_we && w_mtimeHi)
        r_mtime[63:32] <= w_wdata;
      else if (w_tick)
        r_mtime <= r_mtime + 64'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_X) begin
      r_msip <= '0;
      r_mtip <= '0;
      for (int h = 0; h < N_HARTS; h++)
        r_mtimecmp[h] <= '1;
    end else begin
      for (int h = 0; h < N_HARTS; h++) begin
        r_mtip[h] <= (r_mtime >= r_mtimecmp[h]);
        if (w_we && w_msipRgn && (w_msipIdx == 4'(h)))
          r_msip[h] <= w_wdata[0];
        // The two halves are independent; there is no atomic 64-bit update.
        if (w_we && w_cmpRgn && (w_cmpIdx == 4'(h))) begin
          if (w_cmpHiHalf)
            r_mtimecmp[h][63:32] <= w_wdata;
          else
            r_mtimecmp[h][31:0] <= w_wdata;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_X) begin
      r_rdata  <= 32'd0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= w_re;
      if (w_re)
        r_rdata <= w_rdSel;
    end
  end

  assign w_rdata  = r_rdata;
  assign w_rvalid = r_rvalid;
  assign w_mtip   = r_mtip;
  assign w_msip   = r_msip;
  assign w_mtime  = r_mtime;

endmodule

// File: tb/tb_clint_smp.sv
// Bench for clint_smp: two instances (TICK_DIV 4 and 1) share one register bus and are
// checked every cycle against a register-map model, plus a vector table and corner sequences.
module tb_clint_smp;

  localparam int NH = 2;

  typedef struct {
    logic        we;
    logic        re;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [31:0] expRdata;
    logic [1:0]  expMsip;
  } vec_t;

  logic        CLK = 1'b0;
  logic        RST_X;
  logic        we;
  logic        re;
  logic [15:0] addr;
  logic [31:0] wdata;

  logic [31:0] rdata4, rdata1;
  logic        rvalid4, rvalid1;
  logic [1:0]  mtip4, mtip1, msip4, msip1;
  logic [63:0] mtime4, mtime1;

  int nCompared   = 0;
  int nMismatched = 0;

  // Reference model state, one set per instance (index 0: TICK_DIV=4, 1: TICK_DIV=1).
  int          tdOf [2] = '{4, 1};
  logic [63:0] mMtime  [2];
  logic [63:0] mCmp    [2][NH];
  logic [1:0]  mMsip   [2];
  logic [1:0]  mMtip   [2];
  logic [31:0] mRdata  [2];
  logic        mRvalid [2];
  int          mCyc    [2];

  vec_t vecs [18];
  logic [15:0] addrPool [12] = '{16'h0000, 16'h0004, 16'h0008, 16'h4000, 16'h4004, 16'h4008,
                                 16'h400C, 16'h4010, 16'hBFF8, 16'hBFFC, 16'h1234, 16'hBFF0};

  always #5 CLK = ~CLK;

  clint_smp #(.N_HARTS(NH), .TICK_DIV(4)) dutDiv4 (
    .CLK(CLK), .RST_X(RST_X), .w_we(we), .w_re(re), .w_addr(addr), .w_wdata(wdata),
    .w_rdata(rdata4), .w_rvalid(rvalid4), .w_mtip(mtip4), .w_msip(msip4), .w_mtime(mtime4)
  );

  clint_smp #(.N_HARTS(NH), .TICK_DIV(1)) dutDiv1 (
    .CLK(CLK), .RST_X(RST_X), .w_we(we), .w_re(re), .w_addr(addr), .w_wdata(wdata),
    .w_rdata(rdata1), .w_rvalid(rvalid1), .w_mtip(mtip1), .w_msip(msip1), .w_mtime(mtime1)
  );

  task automatic checkVal(input string name, input int d, input logic [63:0] got, input logic [63:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s dut%0d: got %h expected %h", name, d, got, exp);
    end
  endtask

  function automatic logic [31:0] modelRead(input int d, input int w);
    if (w < 4 * NH)
      return {31'd0, mMsip[d][w / 4]};
    if (w >= 'h4000 && w < 'h4000 + 8 * NH)
      return (w % 8 == 4) ? mCmp[d][(w - 'h4000) / 8][63:32] : mCmp[d][(w - 'h4000) / 8][31:0];
    if (w == 'hBFF8)
      return mMtime[d][31:0];
    if (w == 'hBFFC)
      return mMtime[d][63:32];
    return 32'd0;
  endfunction

  // Advances the model by one clock edge using the inputs currently driven.
  task automatic modelStep();
    for (int d = 0; d < 2; d++) begin
      if (!RST_X) begin
        mMtime[d]  = 64'd0;
        mMsip[d]   = 2'b00;
        mMtip[d]   = 2'b00;
        mRdata[d]  = 32'd0;
        mRvalid[d] = 1'b0;
        mCyc[d]    = 0;
        for (int h = 0; h < NH; h++)
          mCmp[d][h] = 64'hFFFF_FFFF_FFFF_FFFF;
      end else begin
        logic [63:0] nextTime;
        logic [31:0] rd;
        logic [1:0]  nextTip;
        bit          timeWritten;
        bit          tick;
        int          w;
        w = int'({addr[15:2], 2'b00});
        rd = modelRead(d, w);
        for (int h = 0; h < NH; h++)
          nextTip[h] = (mMtime[d] >= mCmp[d][h]);
        tick = ((mCyc[d] % tdOf[d]) == tdOf[d] - 1);
        nextTime = mMtime[d];
        timeWritten = 1'b0;
        if (we) begin
          if (w < 4 * NH)
            mMsip[d][w / 4] = wdata[0];
          else if (w >= 'h4000 && w < 'h4000 + 8 * NH) begin
            if (w % 8 == 4)
              mCmp[d][(w - 'h4000) / 8][63:32] = wdata;
            else
              mCmp[d][(w - 'h4000) / 8][31:0] = wdata;
          end else if (w == 'hBFF8) begin
            nextTime[31:0] = wdata;
            timeWritten = 1'b1;
          end else if (w == 'hBFFC) begin
            nextTime[63:32] = wdata;
            timeWritten = 1'b1;
          end
        end
        if (!timeWritten && tick)
          nextTime = nextTime + 64'd1;
        mMtime[d]  = nextTime;
        mMtip[d]   = nextTip;
        mRvalid[d] = re;
        if (re)
          mRdata[d] = rd;
        mCyc[d]++;
      end
    end
  endtask

  task automatic checkOutput();
    checkVal("mtime",  0, mtime4,           mMtime[0]);
    checkVal("mtip",   0, 64'(mtip4),       64'(mMtip[0]));
    checkVal("msip",   0, 64'(msip4),       64'(mMsip[0]));
    checkVal("rvalid", 0, 64'(rvalid4),     64'(mRvalid[0]));
    checkVal("rdata",  0, 64'(rdata4),      64'(mRdata[0]));
    checkVal("mtime",  1, mtime1,           mMtime[1]);
    checkVal("mtip",   1, 64'(mtip1),       64'(mMtip[1]));
    checkVal("msip",   1, 64'(msip1),       64'(mMsip[1]));
    checkVal("rvalid", 1, 64'(rvalid1),     64'(mRvalid[1]));
    checkVal("rdata",  1, 64'(rdata1),      64'(mRdata[1]));
  endtask

  task automatic applyStimulus(input logic rstn, input logic w, input logic r,
                               input logic [15:0] a, input logic [31:0] dat);
    RST_X = rstn;
    we    = w;
    re    = r;
    addr  = a;
    wdata = dat;
    modelStep();
    @(posedge CLK);
    #1;
    checkOutput();
  endtask

  task automatic idle();
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int guard;

    vecs[0]  = '{1'b0, 1'b1, 16'h4000, 32'd0,          32'hFFFF_FFFF, 2'b00};
    vecs[1]  = '{1'b1, 1'b0, 16'h0004, 32'hFFFF_FFFF,  32'd0,         2'b10};
    vecs[2]  = '{1'b0, 1'b1, 16'h0004, 32'd0,          32'h0000_0001, 2'b10};
    vecs[3]  = '{1'b0, 1'b1, 16'h0000, 32'd0,          32'h0000_0000, 2'b10};
    vecs[4]  = '{1'b0, 1'b1, 16'h0006, 32'd0,          32'h0000_0001, 2'b10};
    vecs[5]  = '{1'b1, 1'b0, 16'h4008, 32'h1234_5678,  32'd0,         2'b10};
    vecs[6]  = '{1'b0, 1'b1, 16'h4008, 32'd0,          32'h1234_5678, 2'b10};
    vecs[7]  = '{1'b0, 1'b1, 16'h400C, 32'd0,          32'hFFFF_FFFF, 2'b10};
    vecs[8]  = '{1'b1, 1'b0, 16'h4010, 32'h0000_0005,  32'd0,         2'b10};
    vecs[9]  = '{1'b0, 1'b1, 16'h4010, 32'd0,          32'h0000_0000, 2'b10};
    vecs[10] = '{1'b0, 1'b1, 16'h4014, 32'd0,          32'h0000_0000, 2'b10};
    vecs[11] = '{1'b0, 1'b1, 16'h0008, 32'd0,          32'h0000_0000, 2'b10};
    vecs[12] = '{1'b1, 1'b0, 16'h0008, 32'h0000_0001,  32'd0,         2'b10};
    vecs[13] = '{1'b0, 1'b1, 16'h1000, 32'd0,          32'h0000_0000, 2'b10};
    vecs[14] = '{1'b1, 1'b0, 16'h0004, 32'h0000_0000,  32'd0,         2'b00};
    vecs[15] = '{1'b0, 1'b1, 16'h0004, 32'd0,          32'h0000_0000, 2'b00};
    vecs[16] = '{1'b1, 1'b0, 16'h0000, 32'h0000_0003,  32'd0,         2'b01};
    vecs[17] = '{1'b0, 1'b1, 16'h0000, 32'd0,          32'h0000_0001, 2'b01};

    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 32'd0);
    checkVal("rstMtime",  0, mtime4, 64'd0);
    checkVal("rstRdata",  0, 64'(rdata4), 64'd0);
    checkVal("rstRvalid", 0, 64'(rvalid4), 64'd0);
    checkVal("rstMtip",   1, 64'(mtip1), 64'd0);

    for (int i = 0; i < 40; i++)
      idle();
    checkVal("mtimeAfter40", 0, mtime4, 64'd10);
    checkVal("mtimeAfter40", 1, mtime1, 64'd40);
    checkVal("mtipIdle", 0, 64'(mtip4), 64'd0);
    checkVal("msipIdle", 0, 64'(msip4), 64'd0);

    applyStimulus(1'b1, 1'b0, 1'b1, 16'h4004, 32'd0);
    checkVal("readLatencyValid", 0, 64'(rvalid4), 64'd1);
    checkVal("readCmpHi",        0, 64'(rdata4),  64'hFFFF_FFFF);
    idle();
    checkVal("rvalidDrops", 0, 64'(rvalid4), 64'd0);
    checkVal("rdataHolds",  0, 64'(rdata4),  64'hFFFF_FFFF);

    for (int i = 0; i < 18; i++) begin
      applyStimulus(1'b1, vecs[i].we, vecs[i].re, vecs[i].addr, vecs[i].wdata);
      checkVal("vecMsip", 0, 64'(msip4), 64'(vecs[i].expMsip));
      checkVal("vecMsip", 1, 64'(msip1), 64'(vecs[i].expMsip));
      if (vecs[i].re) begin
        checkVal("vecRdata", 0, 64'(rdata4), 64'(vecs[i].expRdata));
        checkVal("vecRdata", 1, 64'(rdata1), 64'(vecs[i].expRdata));
        checkVal("vecRvalid", 1, 64'(rvalid1), 64'd1);
      end
    end

    applyStimulus(1'b1, 1'b1, 1'b0, 16'h4000, 32'd20);
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h4004, 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 16'hBFF8, 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 16'hBFFC, 32'd0);
    checkVal("mtimeCleared", 1, mtime1, 64'd0);
    guard = 0;
    while (mtime1 != 64'd20 && guard < 100) begin
      idle();
      guard++;
    end
    checkVal("waitMtime20", 1, 64'(guard < 100), 64'd1);
    checkVal("mtipBeforeRise", 1, 64'(mtip1[0]), 64'd0);
    idle();
    checkVal("mtipRise",   1, 64'(mtip1[0]), 64'd1);
    checkVal("mtipOther",  1, 64'(mtip1[1]), 64'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h4004, 32'd1);
    checkVal("mtipStillHigh", 1, 64'(mtip1[0]), 64'd1);
    idle();
    checkVal("mtipDropped", 1, 64'(mtip1[0]), 64'd0);

    applyStimulus(1'b1, 1'b1, 1'b0, 16'hBFF8, 32'hFFFF_FFFE);
    applyStimulus(1'b1, 1'b1, 1'b0, 16'hBFFC, 32'd0);
    idle();
    idle();
    checkVal("mtimeCarry", 1, mtime1, 64'h0000_0001_0000_0000);

    applyStimulus(1'b1, 1'b1, 1'b0, 16'hBFFC, 32'h0000_ABCD);
    checkVal("writeBeatsTick", 1, mtime1, 64'h0000_ABCD_0000_0000);
    applyStimulus(1'b1, 1'b1, 1'b1, 16'hBFF8, 32'h0000_0055);
    checkVal("readOldValue",   1, 64'(rdata1), 64'd0);
    checkVal("writeWithRead",  1, mtime1, 64'h0000_ABCD_0000_0055);

    applyStimulus(1'b1, 1'b0, 1'b1, 16'hBFFC, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0000, 32'd0);
    checkVal("midRstMtime",  1, mtime1, 64'd0);
    checkVal("midRstMtip",   1, 64'(mtip1), 64'd0);
    checkVal("midRstRvalid", 1, 64'(rvalid1), 64'd0);
    checkVal("midRstMsip",   0, 64'(msip4), 64'd0);
    idle();
    checkVal("postRstTick", 1, mtime1, 64'd1);
    checkVal("postRstTick", 0, mtime4, 64'd0);

    for (int i = 0; i < 600; i++) begin
      logic        rstn;
      logic [31:0] dat;
      rstn = ($urandom_range(0, 99) != 0);
      dat  = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 200));
      applyStimulus(rstn, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    addrPool[$urandom_range(0, 11)] | 16'($urandom_range(0, 3)), dat);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/clint_smp.md
Name: clint_smp

Overview:
- Core-local interruptor for the SMP cluster. It keeps the shared 64-bit mtime counter, one mtimecmp and one msip register per hart, and drives the cluster's per-hart w_mtip, w_msip and shared w_mtime inputs.
- It sits upstream of the hart cluster, on the device side of the interconnect.
- Memory-mapped 32-bit register access; 1-cycle registered read latency.

Parameters:
- N_HARTS, 1: number of harts served; legal range 1..16.
- TICK_DIV, 1: CLK cycles per mtime increment; legal range 1..65535.

Ports:
- CLK  in  1  clock.
- RST_X  in  1  reset. Synchronous, active-low.
- w_we  in  1  write strobe for one cycle; 32-bit word write.
- w_re  in  1  read strobe for one cycle.
- w_addr  in  16  byte offset within the CLINT window; bits [1:0] ignored.
- w_wdata  in  32  write data.
- w_rdata  out  32  read data, registered.
- w_rvalid  out  1  pulses 1 cycle after an accepted w_re.
- w_mtip  out  N_HARTS  per-hart machine timer interrupt pending.
- w_msip  out  N_HARTS  per-hart machine software interrupt pending.
- w_mtime  out  64  current mtime value (register output).

Behaviour:
- Register map, word offsets, h = hart index:
  - 0x0000+4h: msip[h]. Only bit0 is implemented; other bits read 0 and writes to them are ignored.
  - 0x4000+8h: mtimecmp[h][31:0].
  - 0x4004+8h: mtimecmp[h][63:32].
  - 0xBFF8: mtime[31:0].
  - 0xBFFC: mtime[63:32].
- Unmapped offsets, and any h >= N_HARTS: reads return 0, writes are dropped, w_rvalid still pulses.
- Reset values:
  - mtime = 0; msip = 0; mtimecmp[h] = 64'hFFFF_FFFF_FFFF_FFFF.
  - Prescaler = 0.
  - w_mtip = 0, w_rdata = 0, w_rvalid = 0.
- Prescaler:
  - Counter counts 0..TICK_DIV-1 and wraps to 0.
  - tick is asserted in the cycle where counter == TICK_DIV-1. With TICK_DIV = 1, tick is asserted every cycle.
- mtime update priority, per cycle:
  - A CPU write to either half of mtime replaces that half with w_wdata and keeps the other half. Any tick in the same cycle is discarded (no increment), and the prescaler keeps counting.
  - Otherwise a tick makes mtime <= mtime + 1 as a full 64-bit add; FFFF_FFFF carries into the high word. 64'hFFFF_FFFF_FFFF_FFFF wraps to 0.
- mtimecmp halves are written independently, with no atomic 64-bit update. Software writes the high word as FFFF_FFFF first to avoid spurious interrupts; the hardware does not enforce this.
- w_mtip[h] is a register: w_mtip[h] <= (mtime >= mtimecmp[h]), unsigned 64-bit compare on current register values.
  - It updates 1 cycle after mtime or mtimecmp changes.
  - It stays high until software raises mtimecmp[h] or lowers mtime.
- w_msip[h] drives msip[h] bit0 directly, so it is visible the cycle after the write.
- w_mtime drives the mtime register directly.
- Read path:
  - w_rdata <= selected value of the registers before any same-cycle write, so a read returns the old value.
  - w_rvalid <= w_re.
  - If w_re and w_we are asserted in the same cycle to the same address: the write takes effect and the read returns the old value.
- Between reads, w_rdata holds its last value.
- Reset asserted mid-operation: all state returns to reset values on that edge. Pending w_rvalid is cleared. No partial write survives.

Test Plan:
- Reset, TICK_DIV=4, N_HARTS=2, no accesses for 40 cycles -> w_mtime = 10. Both bits of w_mtip and w_msip are 0. Reading 0x4004 returns FFFF_FFFF with w_rvalid exactly 1 cycle after w_re.
- Write 0x0004 = 0xFFFF_FFFF -> w_msip = 2'b10 on the next cycle. Reading 0x0004 returns 0x0000_0001. Writing 0x0004 = 0 clears it.
- TICK_DIV=1, write mtimecmp[0] lo = 20, hi = 0; mtime starts at 0 -> w_mtip[0] rises exactly 1 cycle after w_mtime reaches 20. w_mtip[1] stays 0. Writing mtimecmp[0] hi = 1 drops w_mtip[0] 1 cycle later.
- Write mtime lo = FFFF_FFFE, hi = 0 with TICK_DIV=1 -> two ticks later w_mtime = 0x0000_0001_0000_0000 (carry into the high word).
- Write mtime hi in the same cycle as a tick -> mtime = written value with no increment applied. Reading 0xBFF8 in the same cycle as a write to it returns the pre-write value.
- N_HARTS=2, write 0x4010 = 5 and then read it -> returns 0, with no effect on any hart. Assert RST_X=0 for 1 cycle mid-count -> w_mtime = 0 and w_mtip = 0 on the next cycle.
